lifo_mc: RTL and testbench

Multi-channel LIFO (stack) buffer: CHANNELS independent stacks of 2**AWIDTH words each share one memory, partitioned by channel. It supports one push and one pop per clock, on any channels, plus per-channel synchronous clear, per-channel status flags and drop indications. It is the parametrised successor of the single-channel lifo and sits wherever several producers need per-stream last-in-first-out buffering.

---
 rtl/lifo_mc.sv | 189 ++++++++++++++++++
 tb/tb_lifo_mc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_mc.sv
// lifo_mc - multi-channel LIFO (stack) buffer.
//
// CHANNELS independent stacks of 2**AWIDTH words share one memory. Channel c
// owns addresses {c, slot}. One push and one pop are accepted per clock, on
// any channels. Each channel can be cleared synchronously. Per-channel status
// flags are provided, and refused requests are reported with drop pulses.
//
// Ports
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   wrreq_i         push request; wr_ch_i selects the channel, data_i is the word
//   rdreq_i         pop request; rd_ch_i selects the channel
//   clr_i           per-channel synchronous clear (wins over push/pop on that channel)
//   q_o             popped word, registered one cycle after the pop; holds otherwise
//   q_valid_o       one-cycle strobe qualifying q_o
//   q_ch_o          channel that q_o came from
//   empty_o, full_o, almost_empty_o, almost_full_o   per-channel flags
//   usedw_o         per-channel occupancy, channel c at [c*(AWIDTH+1) +: AWIDTH+1]
//   wr_drop_o       pulse: push refused (channel full or channel index invalid)
//   rd_drop_o       pulse: pop refused (channel empty or channel index invalid)
module lifo_mc #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int CHANNELS     = 4,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2,
    parameter int CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             wrreq_i,
    input  logic [CHW-1:0]                   wr_ch_i,
    input  logic [DWIDTH-1:0]                data_i,
    input  logic                             rdreq_i,
    input  logic [CHW-1:0]                   rd_ch_i,
    input  logic [CHANNELS-1:0]              clr_i,
    output logic [DWIDTH-1:0]                q_o,
    output logic                             q_valid_o,
    output logic [CHW-1:0]                   q_ch_o,
    output logic [CHANNELS-1:0]              empty_o,
    output logic [CHANNELS-1:0]              full_o,
    output logic [CHANNELS-1:0]              almost_empty_o,
    output logic [CHANNELS-1:0]              almost_full_o,
    output logic [CHANNELS*(AWIDTH+1)-1:0]   usedw_o,
    output logic                             wr_drop_o,
    output logic                             rd_drop_o
);

    localparam int              DEPTH    = 1 << AWIDTH;
    localparam int              AW1      = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH_V  = AW1'(DEPTH);
    localparam logic [AWIDTH:0] AE_LEVEL = AW1'(ALMOST_EMPTY);
    localparam logic [AWIDTH:0] AF_LEVEL = AW1'(DEPTH - ALMOST_FULL);

    // Storage: not reset, inferred as block RAM with a registered read.
    logic [DWIDTH-1:0] mem [CHANNELS*DEPTH];

    // Per-channel stack pointer == occupancy; top of stack is ptr-1.
    logic [AWIDTH:0] ptr_reg  [CHANNELS];
    logic [AWIDTH:0] ptr_next [CHANNELS];

    logic [CHANNELS-1:0] empty_reg, full_reg, almost_empty_reg, almost_full_reg;
    logic [DWIDTH-1:0]   q_reg;
    logic [CHW-1:0]      q_ch_reg;
    logic                q_valid_reg, wr_drop_reg, rd_drop_reg;

    // Request decode
    logic                 wr_ch_ok, rd_ch_ok;
    logic [AWIDTH:0]      wr_ptr, rd_ptr;
    logic                 wr_clr, rd_clr;
    logic                 wr_valid, rd_valid;
    logic                 pop_ok, push_ok, swap, same_ch;
    logic                 wr_drop_next, rd_drop_next;
    logic [AWIDTH:0]      wr_slot, rd_slot;
    logic [CHW+AWIDTH-1:0] wr_addr, rd_addr;

    // Look up the addressed channels' pointer and clear bit through a mux
    // loop so an out-of-range index simply matches nothing.
    always_comb begin
        wr_ptr   = '0;
        rd_ptr   = '0;
        wr_clr   = 1'b0;
        rd_clr   = 1'b0;
        wr_ch_ok = 1'b0;
        rd_ch_ok = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(wr_ch_i) == c) begin
                wr_ptr   = ptr_reg[c];
                wr_clr   = clr_i[c];
                wr_ch_ok = 1'b1;
            end
            if (int'(rd_ch_i) == c) begin
                rd_ptr   = ptr_reg[c];
                rd_clr   = clr_i[c];
                rd_ch_ok = 1'b1;
            end
        end
    end

    always_comb begin
        same_ch  = (wr_ch_i == rd_ch_i);
        wr_valid = wrreq_i && wr_ch_ok;
        rd_valid = rdreq_i && rd_ch_ok;
        pop_ok   = rd_valid && !rd_clr && (rd_ptr != '0);
        // A full channel still accepts a push when the same cycle pops it:
        // the new word replaces the top in place.
        push_ok  = wr_valid && !wr_clr && ((wr_ptr != DEPTH_V) || (pop_ok && same_ch));
        swap     = push_ok && pop_ok && same_ch;
        // Requests discarded by a clear are silent, not drops.
        wr_drop_next = wrreq_i && !push_ok && !(wr_valid && wr_clr);
        rd_drop_next = rdreq_i && !pop_ok  && !(rd_valid && rd_clr);
        rd_slot  = rd_ptr - 1'b1;
        wr_slot  = swap ? (wr_ptr - 1'b1) : wr_ptr;
        wr_addr  = {wr_ch_i, wr_slot[AWIDTH-1:0]};
        rd_addr  = {rd_ch_i, rd_slot[AWIDTH-1:0]};
    end

    // Next pointer per channel. A swap leaves its channel's pointer alone.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ptr_next[c] = ptr_reg[c];
            if (clr_i[c]) begin
                ptr_next[c] = '0;
            end else if (!swap && push_ok && (int'(wr_ch_i) == c)) begin
                ptr_next[c] = ptr_reg[c] + 1'b1;
            end else if (!swap && pop_ok && (int'(rd_ch_i) == c)) begin
                ptr_next[c] = ptr_reg[c] - 1'b1;
            end
        end
    end

    // Memory write port. The read happens in the output register below in
    // the same edge, so a swap returns the old top (read-before-write).
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_addr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_reg[c] <= '0;
            end
            empty_reg        <= '1;
            almost_empty_reg <= '1;
            full_reg         <= '0;
            almost_full_reg  <= '0;
            q_reg            <= '0;
            q_ch_reg         <= '0;
            q_valid_reg      <= 1'b0;
            wr_drop_reg      <= 1'b0;
            rd_drop_reg      <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_reg[c]          <= ptr_next[c];
                empty_reg[c]        <= (ptr_next[c] == '0);
                full_reg[c]         <= (ptr_next[c] == DEPTH_V);
                almost_empty_reg[c] <= (ptr_next[c] <= AE_LEVEL);
                almost_full_reg[c]  <= (ptr_next[c] >= AF_LEVEL);
            end
            q_valid_reg <= pop_ok;
            wr_drop_reg <= wr_drop_next;
            rd_drop_reg <= rd_drop_next;
            if (pop_ok) begin
                q_reg    <= mem[rd_addr];
                q_ch_reg <= rd_ch_i;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_usedw
            assign usedw_o[gi*AW1 +: AW1] = ptr_reg[gi];
        end
    endgenerate

    assign q_o            = q_reg;
    assign q_ch_o         = q_ch_reg;
    assign q_valid_o      = q_valid_reg;
    assign empty_o        = empty_reg;
    assign full_o         = full_reg;
    assign almost_empty_o = almost_empty_reg;
    assign almost_full_o  = almost_full_reg;
    assign wr_drop_o      = wr_drop_reg;
    assign rd_drop_o      = rd_drop_reg;

endmodule

// File: tb/tb_lifo_mc.sv
// tb_lifo_mc - self-checking bench for lifo_mc (default parameters).
// The reference is one queue per channel: push_back / pop_back, with the
// accept/refuse rules applied in plain terms. A compare process checks every
// output on each falling edge; directed sections add literal expectations.
module tb_lifo_mc;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int CH    = 4;
    localparam int CHW   = 2;
    localparam int DEPTH = 256;
    localparam int UW    = AW + 1;
    localparam int AF    = 2;
    localparam int AE    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wrreq = 1'b0, rdreq = 1'b0;
    logic [CHW-1:0]    wr_ch = '0, rd_ch = '0;
    logic [DW-1:0]     data = '0;
    logic [CH-1:0]     clr = '0;
    logic [DW-1:0]     q_o;
    logic              q_valid_o;
    logic [CHW-1:0]    q_ch_o;
    logic [CH-1:0]     empty_o, full_o, almost_empty_o, almost_full_o;
    logic [CH*UW-1:0]  usedw_o;
    logic              wr_drop_o, rd_drop_o;

    lifo_mc #(
        .DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wrreq_i(wrreq), .wr_ch_i(wr_ch), .data_i(data),
        .rdreq_i(rdreq), .rd_ch_i(rd_ch), .clr_i(clr),
        .q_o(q_o), .q_valid_o(q_valid_o), .q_ch_o(q_ch_o),
        .empty_o(empty_o), .full_o(full_o),
        .almost_empty_o(almost_empty_o), .almost_full_o(almost_full_o),
        .usedw_o(usedw_o), .wr_drop_o(wr_drop_o), .rd_drop_o(rd_drop_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model state and the outputs it predicts.
    logic [DW-1:0]  stk [CH][$];
    int             exp_used [CH];
    logic           exp_qv, exp_wd, exp_rd;
    logic [DW-1:0]  exp_q;
    logic [CHW-1:0] exp_qch;
    bit             check_en = 1'b0;

    function automatic void check(string name, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endfunction

    function automatic int usedw_of(int c);
        return int'(usedw_o[c*UW +: UW]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            stk[c].delete();
            exp_used[c] = 0;
        end
        exp_qv  = 1'b0;
        exp_wd  = 1'b0;
        exp_rd  = 1'b0;
        exp_q   = '0;
        exp_qch = '0;
    endtask

    // Every output, every cycle, against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int c = 0; c < CH; c++) begin
                check($sformatf("usedw[%0d]", c), usedw_of(c), exp_used[c]);
                check($sformatf("empty[%0d]", c), empty_o[c], exp_used[c] == 0);
                check($sformatf("full[%0d]", c), full_o[c], exp_used[c] == DEPTH);
                check($sformatf("almost_empty[%0d]", c), almost_empty_o[c], exp_used[c] <= AE);
                check($sformatf("almost_full[%0d]", c), almost_full_o[c], exp_used[c] >= DEPTH - AF);
            end
            check("q_valid", q_valid_o, exp_qv);
            check("q", q_o, exp_q);
            if (exp_qv) check("q_ch", q_ch_o, exp_qch);
            check("wr_drop", wr_drop_o, exp_wd);
            check("rd_drop", rd_drop_o, exp_rd);
        end
    end

    // One clock of stimulus: drive on the falling edge, advance the model,
    // publish its prediction just after the rising edge.
    task automatic step(input logic w, input logic [CHW-1:0] wc, input logic [DW-1:0] d,
                        input logic r, input logic [CHW-1:0] rc, input logic [CH-1:0] cl);
        bit            pop_ok, push_ok, same, wd, rdd;
        logic [DW-1:0] popped;
        popped = '0;
        @(negedge clk);
        wrreq = w; wr_ch = wc; data = d; rdreq = r; rd_ch = rc; clr = cl;
        pop_ok  = r && !cl[rc] && (stk[rc].size() > 0);
        same    = pop_ok && w && (wc == rc);
        push_ok = w && !cl[wc] && ((stk[wc].size() < DEPTH) || same);
        wd      = w && !push_ok && !cl[wc];
        rdd     = r && !pop_ok && !cl[rc];
        if (pop_ok)  popped = stk[rc].pop_back();
        if (push_ok) stk[wc].push_back(d);
        for (int c = 0; c < CH; c++) if (cl[c]) stk[c].delete();
        n_txn++;
        $display("txn %0d: wr=%b ch%0d d=%h | rd=%b ch%0d | clr=%b -> push=%b pop=%b q=%h",
                 n_txn, w, wc, d, r, rc, cl, push_ok, pop_ok, popped);
        @(posedge clk);
        #1;
        exp_qv = pop_ok;
        exp_wd = wd;
        exp_rd = rdd;
        if (pop_ok) begin
            exp_q   = popped;
            exp_qch = rc;
        end
        for (int c = 0; c < CH; c++) exp_used[c] = stk[c].size();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset mid-cycle, held for three edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        wrreq = 1'b0; rdreq = 1'b0; clr = '0;
        model_reset();
        $display("txn %0d: reset asserted", n_txn);
        repeat (3) @(posedge clk);
        #1;
        check("rst usedw all", usedw_o, 0);
        check("rst empty", empty_o, 4'hF);
        check("rst almost_empty", almost_empty_o, 4'hF);
        check("rst full", full_o, 0);
        check("rst almost_full", almost_full_o, 0);
        check("rst q_valid", q_valid_o, 0);
        check("rst q", q_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic           w, r;
        logic [CHW-1:0] wc, rc, mainc;
        logic [CH-1:0]  cl;

        model_reset();
        #1;
        check_en = 1'b1;
        do_reset();

        // Fill channel 2 with 0..255, then one extra push.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 2'd2, 16'(i), 1'b0, '0, '0);
            if (i == 252) check("af at 253", almost_full_o[2], 0);
            if (i == 253) check("af at 254", almost_full_o[2], 1);
        end
        step(1'b1, 2'd2, 16'hFFFF, 1'b0, '0, '0);
        check("overflow drop", wr_drop_o, 1);
        check("ch2 full", full_o[2], 1);
        check("ch2 usedw 256", usedw_of(2), 256);

        // Drain it: values come back 255..0.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, '0, 1'b1, 2'd2, '0);
            check("drain q", q_o, 255 - i);
            check("drain q_ch", q_ch_o, 2);
            if (255 - i == 3) check("ae at 3", almost_empty_o[2], 0);
            if (255 - i == 2) check("ae at 2", almost_empty_o[2], 1);
        end
        check("ch2 empty", empty_o[2], 1);

        // Underflow on channel 0.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 2'd0, '0);
            check("underflow drop", rd_drop_o, 1);
            check("underflow q_valid", q_valid_o, 0);
        end
        check("ch0 usedw 0", usedw_of(0), 0);

        // Push ch0 while popping ch1.
        step(1'b1, 2'd1, 16'hB1B1, 1'b0, '0, '0);
        step(1'b1, 2'd0, 16'hA0A0, 1'b1, 2'd1, '0);
        check("interleave q", q_o, 16'hB1B1);
        check("interleave usedw0", usedw_of(0), 1);
        check("interleave usedw1", usedw_of(1), 0);

        // Same-channel push+pop on a full channel 3.
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 2'd3, 16'($urandom), 1'b0, '0, '0);
        step(1'b1, 2'd3, 16'h1234, 1'b0, '0, '0);
        step(1'b1, 2'd3, 16'h5678, 1'b1, 2'd3, '0);
        check("swap q", q_o, 16'h1234);
        check("swap usedw3", usedw_of(3), 256);
        check("swap no wr_drop", wr_drop_o, 0);
        step(1'b0, '0, '0, 1'b1, 2'd3, '0);
        check("after swap q", q_o, 16'h5678);

        // Clear channel 1 while popping it.
        for (int i = 0; i < 10; i++) step(1'b1, 2'd1, 16'(16'hC100 + i), 1'b0, '0, '0);
        check("ch1 usedw 10", usedw_of(1), 10);
        step(1'b0, '0, '0, 1'b1, 2'd1, 4'b0010);
        check("clr usedw1", usedw_of(1), 0);
        check("clr q_valid", q_valid_o, 0);
        check("clr no rd_drop", rd_drop_o, 0);
        check("clr usedw0 kept", usedw_of(0), 1);
        check("clr usedw3 kept", usedw_of(3), 255);
        idle();

        // Random traffic: alternating push-heavy / pop-heavy phases, each
        // focused on one channel so stacks reach both full and empty.
        for (int ph = 0; ph < 8; ph++) begin
            mainc = 2'(ph % CH);
            for (int k = 0; k < 400; k++) begin
                w  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 90 : 20));
                r  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 10 : 85));
                wc = ($urandom_range(0, 99) < 80) ? mainc : 2'($urandom_range(0, 3));
                rc = ($urandom_range(0, 99) < 80) ? mainc : 2'($urandom_range(0, 3));
                cl = ($urandom_range(0, 127) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
                step(w, wc, 16'($urandom), r, rc, cl);
            end
        end

        // Reset in the middle of a fill.
        for (int i = 0; i < 20; i++) step(1'b1, 2'd0, 16'(i), 1'b1, 2'd1, '0);
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), '0);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
